// File: rtl/segre_pkg.sv
// segre_pkg: shared types and constants for the memory arbiter slice
package segre_pkg;
  localparam int ICACHE_LANE_SIZE = 128;
  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_IC_FILL,
    ARB_DC_WB,
    ARB_DC_FILL,
    ARB_RESP
  } arb_fsm_state_e;
  typedef enum logic {
    ARB_GRANT_IC,
    ARB_GRANT_DC
  } arb_grant_e;
  function automatic int lane_offset(input int lane_bits);
    return $clog2(lane_bits / 8);
  endfunction
endpackage

// File: rtl/segre_lru_counter.sv
// segre_lru_counter: FIFO-replacement victim index, wraps modulo 2^W
module segre_lru_counter #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk_i) begin
    if (rst_i) count <= '0;
    else if (inc) count <= count + W'(1);
  end
endmodule

// File: rtl/segre_mem_arbiter.sv
// segre_mem_arbiter: serialises icache/dcache misses onto one memory port,
// with dcache dirty-victim writeback ahead of the refill.
module segre_mem_arbiter
  import segre_pkg::*;
#(
  parameter int ADDR_SIZE     = 32,
  parameter int LANE_SIZE     = ICACHE_LANE_SIZE,
  parameter int IC_INDEX_SIZE = 2,
  parameter int DC_INDEX_SIZE = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     ic_miss_i,
  input  logic [ADDR_SIZE-1:0]     ic_addr_i,
  output logic                     ic_fill_o,
  output logic [LANE_SIZE-1:0]     ic_fill_data_o,
  output logic [IC_INDEX_SIZE-1:0] ic_lru_index_o,
  input  logic                     dc_miss_i,
  input  logic [ADDR_SIZE-1:0]     dc_addr_i,
  input  logic                     dc_wb_i,
  input  logic [ADDR_SIZE-1:0]     dc_wb_addr_i,
  input  logic [LANE_SIZE-1:0]     dc_wb_data_i,
  output logic                     dc_fill_o,
  output logic [LANE_SIZE-1:0]     dc_fill_data_o,
  output logic [DC_INDEX_SIZE-1:0] dc_lru_index_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ADDR_SIZE-1:0]     mem_addr_o,
  output logic [LANE_SIZE-1:0]     mem_wr_data_o,
  input  logic                     mem_ready_i,
  input  logic [LANE_SIZE-1:0]     mem_rd_data_i
);
  localparam int OFF = lane_offset(LANE_SIZE);
  arb_fsm_state_e       state;
  arb_grant_e           last_grant;
  logic [1:0]           served;
  logic [ADDR_SIZE-1:0] fill_addr;
  logic [LANE_SIZE-1:0] lane;
  logic [ADDR_SIZE-1:0] ic_line, dc_line, wb_line;
  logic                 ic_elig, dc_elig, pick_dc;
  assign ic_line = {ic_addr_i[ADDR_SIZE-1:OFF], {OFF{1'b0}}};
  assign dc_line = {dc_addr_i[ADDR_SIZE-1:OFF], {OFF{1'b0}}};
  assign wb_line = {dc_wb_addr_i[ADDR_SIZE-1:OFF], {OFF{1'b0}}};
  // A requester just served is masked for one cycle so its stale level miss is not re-granted
  always_comb begin
    ic_elig = ic_miss_i & ~served[0];
    dc_elig = dc_miss_i & ~served[1];
    pick_dc = dc_elig & (~ic_elig | (last_grant == ARB_GRANT_IC));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ARB_IDLE;
      last_grant    <= ARB_GRANT_IC;
      served        <= '0;
      fill_addr     <= '0;
      lane          <= '0;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wr_data_o <= '0;
      ic_fill_o     <= 1'b0;
      dc_fill_o     <= 1'b0;
    end else begin
      ic_fill_o <= 1'b0;
      dc_fill_o <= 1'b0;
      served    <= '0;
      case (state)
        ARB_IDLE:
          if (pick_dc) begin
            last_grant    <= ARB_GRANT_DC;
            fill_addr     <= dc_line;
            mem_req_o     <= 1'b1;
            mem_we_o      <= dc_wb_i;
            mem_addr_o    <= dc_wb_i ? wb_line : dc_line;
            mem_wr_data_o <= dc_wb_data_i;
            state         <= dc_wb_i ? ARB_DC_WB : ARB_DC_FILL;
          end else if (ic_elig) begin
            last_grant <= ARB_GRANT_IC;
            fill_addr  <= ic_line;
            mem_req_o  <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_addr_o <= ic_line;
            state      <= ARB_IC_FILL;
          end
        ARB_DC_WB:
          if (mem_ready_i) begin
            mem_we_o   <= 1'b0;
            mem_addr_o <= fill_addr;
            state      <= ARB_DC_FILL;
          end
        ARB_IC_FILL, ARB_DC_FILL:
          if (mem_ready_i) begin
            lane      <= mem_rd_data_i;
            mem_req_o <= 1'b0;
            ic_fill_o <= last_grant == ARB_GRANT_IC;
            dc_fill_o <= last_grant == ARB_GRANT_DC;
            state     <= ARB_RESP;
          end
        ARB_RESP: begin
          served <= {last_grant == ARB_GRANT_DC, last_grant == ARB_GRANT_IC};
          state  <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
  assign ic_fill_data_o = lane;
  assign dc_fill_data_o = lane;
  segre_lru_counter #(.W(IC_INDEX_SIZE)) u_ic_lru (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (state == ARB_RESP && last_grant == ARB_GRANT_IC),
    .count (ic_lru_index_o)
  );
  segre_lru_counter #(.W(DC_INDEX_SIZE)) u_dc_lru (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (state == ARB_RESP && last_grant == ARB_GRANT_DC),
    .count (dc_lru_index_o)
  );
endmodule

// File: tb/tb_segre_mem_arbiter.sv
// tb_segre_mem_arbiter: directed checks of arbitration, writeback, victim index and reset
module tb_segre_mem_arbiter;
  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         ic_miss_i = 1'b0, dc_miss_i = 1'b0, dc_wb_i = 1'b0, mem_ready_i = 1'b0;
  logic [31:0]  ic_addr_i = '0, dc_addr_i = '0, dc_wb_addr_i = '0;
  logic [127:0] dc_wb_data_i = '0, mem_rd_data_i = '0;
  logic         ic_fill_o, dc_fill_o, mem_req_o, mem_we_o;
  logic [127:0] ic_fill_data_o, dc_fill_data_o, mem_wr_data_o;
  logic [1:0]   ic_lru_index_o, dc_lru_index_o;
  logic [31:0]  mem_addr_o;
  int n_chk = 0, n_err = 0;
  localparam logic [127:0] L1 = 128'hDEAD0000_11112222_33334444_0000BEEF;
  localparam logic [127:0] L2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] L3 = 128'hA5A5_A5A5_5A5A_5A5A_C3C3_C3C3_3C3C_3C3C;
  localparam logic [127:0] L4 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] WB = 128'hBADC0FFE_E0DDF00D_0BADBEEF_12345678;
  segre_mem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ic_miss_i(ic_miss_i), .ic_addr_i(ic_addr_i), .ic_fill_o(ic_fill_o),
    .ic_fill_data_o(ic_fill_data_o), .ic_lru_index_o(ic_lru_index_o),
    .dc_miss_i(dc_miss_i), .dc_addr_i(dc_addr_i), .dc_wb_i(dc_wb_i),
    .dc_wb_addr_i(dc_wb_addr_i), .dc_wb_data_i(dc_wb_data_i), .dc_fill_o(dc_fill_o),
    .dc_fill_data_o(dc_fill_data_o), .dc_lru_index_o(dc_lru_index_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wr_data_o(mem_wr_data_o), .mem_ready_i(mem_ready_i), .mem_rd_data_i(mem_rd_data_i)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic do_reset();
    rst_i = 1'b1;
    ic_miss_i = 1'b0;
    dc_miss_i = 1'b0;
    dc_wb_i = 1'b0;
    mem_ready_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask
  task automatic serve(input string tag, input logic we, input logic [31:0] addr,
                       input logic [127:0] wd, input logic [127:0] rd, input int dly);
    check({tag, "_req"}, 128'(mem_req_o), 128'(1'b1));
    check({tag, "_we"}, 128'(mem_we_o), 128'(we));
    check({tag, "_addr"}, 128'(mem_addr_o), 128'(addr));
    if (we) check({tag, "_wdata"}, mem_wr_data_o, wd);
    repeat (dly) tick();
    if (dly > 0) check({tag, "_hold"}, 128'(mem_req_o), 128'(1'b1));
    mem_ready_i = 1'b1;
    mem_rd_data_i = rd;
    tick();
    mem_ready_i = 1'b0;
    mem_rd_data_i = '0;
  endtask
  task automatic fill_chk(input string tag, input logic ic, input logic [127:0] d, input logic [1:0] idx);
    check({tag, "_icf"}, 128'(ic_fill_o), 128'(ic));
    check({tag, "_dcf"}, 128'(dc_fill_o), 128'(!ic));
    check({tag, "_data"}, ic ? ic_fill_data_o : dc_fill_data_o, d);
    check({tag, "_idx"}, 128'(ic ? ic_lru_index_o : dc_lru_index_o), 128'(idx));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    do_reset();
    check("rst_req", 128'(mem_req_o), 128'(1'b0));
    check("rst_we", 128'(mem_we_o), 128'(1'b0));
    check("rst_addr", 128'(mem_addr_o), 128'(0));
    check("rst_fills", 128'({ic_fill_o, dc_fill_o}), 128'(0));
    check("rst_idx", 128'({ic_lru_index_o, dc_lru_index_o}), 128'(0));
    check("rst_data", ic_fill_data_o, 128'(0));
    // single icache miss, memory ready after two wait cycles
    ic_addr_i = 32'h0000_1004;
    ic_miss_i = 1'b1;
    tick();
    serve("ic1", 1'b0, 32'h0000_1000, '0, L1, 2);
    fill_chk("ic1", 1'b1, L1, 2'd0);
    ic_miss_i = 1'b0;
    tick();
    check("ic1_pulse", 128'(ic_fill_o), 128'(1'b0));
    check("ic1_next_idx", 128'(ic_lru_index_o), 128'(2'd1));
    check("ic1_idle_req", 128'(mem_req_o), 128'(1'b0));
    tick();
    // tie after reset: dcache first, then icache
    do_reset();
    ic_addr_i = 32'h0000_1004;
    dc_addr_i = 32'h0000_3008;
    ic_miss_i = 1'b1;
    dc_miss_i = 1'b1;
    tick();
    serve("tie1_dc", 1'b0, 32'h0000_3000, '0, L2, 0);
    fill_chk("tie1_dc", 1'b0, L2, 2'd0);
    dc_miss_i = 1'b0;
    tick();
    check("tie1_gap", 128'(mem_req_o), 128'(1'b0));
    tick();
    serve("tie1_ic", 1'b0, 32'h0000_1000, '0, L3, 1);
    fill_chk("tie1_ic", 1'b1, L3, 2'd0);
    ic_miss_i = 1'b0;
    tick();
    tick();
    dc_addr_i = 32'h0000_5000;
    dc_miss_i = 1'b1;
    tick();
    serve("solo_dc", 1'b0, 32'h0000_5000, '0, L4, 0);
    fill_chk("solo_dc", 1'b0, L4, 2'd1);
    dc_miss_i = 1'b0;
    tick();
    tick();
    // tie after a dcache grant: icache wins
    ic_addr_i = 32'h0000_6004;
    dc_addr_i = 32'h0000_7000;
    ic_miss_i = 1'b1;
    dc_miss_i = 1'b1;
    tick();
    serve("tie2_ic", 1'b0, 32'h0000_6000, '0, L1, 0);
    fill_chk("tie2_ic", 1'b1, L1, 2'd1);
    ic_miss_i = 1'b0;
    tick();
    tick();
    serve("tie2_dc", 1'b0, 32'h0000_7000, '0, L2, 0);
    fill_chk("tie2_dc", 1'b0, L2, 2'd2);
    dc_miss_i = 1'b0;
    tick();
    tick();
    // dirty victim: write back first, then refill
    dc_addr_i = 32'h0000_4010;
    dc_wb_i = 1'b1;
    dc_wb_addr_i = 32'h0000_2000;
    dc_wb_data_i = WB;
    dc_miss_i = 1'b1;
    tick();
    serve("wb", 1'b1, 32'h0000_2000, WB, '0, 1);
    dc_wb_i = 1'b0;
    serve("wb_rd", 1'b0, 32'h0000_4010, '0, L3, 0);
    fill_chk("wb_rd", 1'b0, L3, 2'd3);
    dc_miss_i = 1'b0;
    tick();
    check("wb_single", 128'(dc_fill_o), 128'(1'b0));
    tick();
    // victim index wraps 3 -> 0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ic_addr_i = (32'(i) << 8) | 32'h8;
      ic_miss_i = 1'b1;
      tick();
      serve("wrap", 1'b0, 32'(i) << 8, '0, {96'h0, 32'(i) ^ 32'hA5A5_0000}, 0);
      fill_chk("wrap", 1'b1, {96'h0, 32'(i) ^ 32'hA5A5_0000}, 2'(i % 4));
      ic_miss_i = 1'b0;
      tick();
      tick();
    end
    // miss held past the fill is not re-granted
    ic_addr_i = 32'h0000_8000;
    ic_miss_i = 1'b1;
    tick();
    serve("hold", 1'b0, 32'h0000_8000, '0, L4, 0);
    fill_chk("hold", 1'b1, L4, 2'd1);
    tick();
    check("hold_r1", 128'(mem_req_o), 128'(1'b0));
    tick();
    check("hold_r2", 128'(mem_req_o), 128'(1'b0));
    ic_miss_i = 1'b0;
    tick();
    check("hold_r3", 128'(mem_req_o), 128'(1'b0));
    // ready with no request outstanding is ignored
    mem_ready_i = 1'b1;
    mem_rd_data_i = L1;
    tick();
    mem_ready_i = 1'b0;
    check("stray_ready", 128'({mem_req_o, ic_fill_o, dc_fill_o}), 128'(0));
    tick();
    // reset while waiting on memory
    ic_addr_i = 32'h0000_9000;
    ic_miss_i = 1'b1;
    tick();
    check("mid_req", 128'(mem_req_o), 128'(1'b1));
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    ic_miss_i = 1'b0;
    check("mid_rst_req", 128'(mem_req_o), 128'(1'b0));
    check("mid_rst_fill", 128'(ic_fill_o), 128'(1'b0));
    check("mid_rst_idx", 128'(ic_lru_index_o), 128'(2'd0));
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    check("mid_no_fill", 128'({ic_fill_o, mem_req_o}), 128'(0));
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
